y_misr_compactor: RTL and testbench
===================================

Name: y_misr_compactor

Overview:
- Downstream consumer of the 82-bit `top` output bus `y`, placed in the synthesised-netlist simulation harness.
- Compresses one `y` sample per clock over a fixed stimulus window into a multiple-input signature register (MISR).
- Compares the final signature with a golden value, so the result from one simulator/synthesis flow can be checked against another from a single word, not a per-cycle `$strobe` dump.

Parameters:
- WIDTH, 82, width of `y_in`, `golden` and `sig_out`.
- POLY, 82'h0_0000_0000_0000_0000_0061, feedback taps XORed in when the signature MSB is 1.
- SEED, 82'h1, value loaded into the signature on start.
- NUM_VEC, 21, number of `y` samples absorbed per run; legal range 1..65535.
- CW, 16, width of the sample counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, begin a run; sampled only in IDLE or DONE.
- y_in, input, WIDTH, `top.y` sample.
- golden, input, WIDTH, expected final signature; sampled on the final absorb edge.
- sig_out, output, WIDTH, current signature register.
- cnt, output, CW, samples absorbed in the current run.
- busy, output, 1, high while in RUN.
- done, output, 1, high in DONE.
- match, output, 1, registered result of (final signature == golden); valid only while done = 1.

Behaviour:
- Reset: on rising clk edge with rst_n = 0, set state = IDLE and sig_out = 0, cnt = 0, busy = 0, done = 0, match = 0. Reset overrides start and all other activity, including mid-RUN; the partial signature is discarded.
- Step function: next(s,d) = ({s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? POLY : 0)) ^ d.
- States: IDLE, RUN, DONE. All outputs are registered; no combinational path from any input to any output.
- IDLE, start = 1: sig_out <= SEED, cnt <= 0, busy <= 1, done <= 0, match <= 0, go to RUN. `y_in` is not absorbed on this edge.
- IDLE, start = 0: hold.
- RUN, every edge: sig_out <= next(sig_out, y_in), cnt <= cnt + 1.
- RUN, when cnt == NUM_VEC-1 (last absorb):
  - go to DONE; busy <= 0, done <= 1.
  - match <= (next(sig_out, y_in) == golden).
- RUN: start is ignored.
- DONE: sig_out, cnt and match hold. start = 1 restarts exactly as from IDLE (done drops on that edge).
- Latency:
  - first absorb occurs on the edge after the start edge;
  - done rises on the edge that absorbs sample NUM_VEC;
  - total is NUM_VEC+1 edges from the start edge.
- NUM_VEC = 1: one RUN cycle, then DONE.
- cnt never wraps within a legal run; cnt == NUM_VEC in DONE.
- X/Z on y_in propagates into sig_out. No masking is done; a non-0/1 signature is itself a fail indication to the harness.

Test Plan:
1. Reset mid-run: WIDTH = 8, POLY = 8'h1D, SEED = 8'h00, NUM_VEC = 4. Pulse start, absorb 2 samples, then rst_n = 0 for 1 edge -> next cycle sig_out = 0, cnt = 0, busy = 0, done = 0, state IDLE; a later start runs normally.
2. Basic signature: same parameters as scenario 1 but NUM_VEC = 2; start, then y_in = 8'h80, then 8'h00; golden = 8'h1D.
   - After edge 1: sig_out = 8'h80.
   - After edge 2: sig_out = 8'h1D, done = 1, match = 1, cnt = 2, busy = 0.
3. Mismatch: repeat scenario 2 with golden = 8'h1C -> done = 1, match = 0, sig_out = 8'h1D.
4. Start ignored in RUN: same parameters as scenario 1 (NUM_VEC = 4). Assert start again on the 2nd RUN cycle -> run still ends after exactly 4 absorbs, done on the 5th edge after the first start, cnt = 4.
5. Restart from DONE and NUM_VEC = 1: WIDTH = 8, POLY = 8'h1D, SEED = 8'h01, NUM_VEC = 1, y_in = 8'h01 -> sig_out = 8'h03 (02 ^ 01), done = 1 one edge after RUN entry. A second start reloads SEED, done = 0 for one cycle, then done = 1 again with the same result.
6. Default config (WIDTH = 82, NUM_VEC = 21) driven by `top` with the 21-vector stimulus set -> signature from RTL-sim equals signature from netlist-sim; match = 1 with that value as golden.

Source files
------------

// File: rtl/y_misr_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : y_misr_compactor                                             |
// | Description : Multiple-input signature register that compresses one        |
// |               sample of the top-level y bus per clock over a fixed window  |
// |               and compares the final signature against a golden word.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module y_misr_compactor #(
   parameter int               WIDTH   = 82,
   parameter logic [WIDTH-1:0] POLY    = 'h61,
   parameter logic [WIDTH-1:0] SEED    = 'h1,
   parameter int               NUM_VEC = 21,
   parameter int               CW      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] golden,
   output logic [WIDTH-1:0] sig_out,
   output logic [CW-1:0]    cnt,
   output logic             busy,
   output logic             done,
   output logic             match
);

   localparam logic [1:0]    S_IDLE = 2'd0;
   localparam logic [1:0]    S_RUN  = 2'd1;
   localparam logic [1:0]    S_DONE = 2'd2;

   // Counter value present while the final sample is being absorbed.
   localparam logic [CW-1:0] C_LAST = CW'(NUM_VEC - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             match_q, match_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] w_fb;
   logic [WIDTH-1:0] w_next;
   logic             w_last;

   // Signature step: shift left, fold in taps when MSB drops out, XOR sample.
   // X/Z on y_in is deliberately allowed to propagate into the signature.
   assign w_fb   = sig_q[WIDTH-1] ? POLY : '0;
   assign w_next = {sig_q[WIDTH-2:0], 1'b0} ^ w_fb ^ y_in;
   assign w_last = (cnt_q == C_LAST);

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start is only honoured outside RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (w_last) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode computed from the next state so busy/done are registered.
   always_comb begin
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // Datapath next-value: seed on start, absorb in RUN, hold otherwise.
   always_comb begin
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      match_d = match_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               sig_d   = SEED;
               cnt_d   = '0;
               match_d = 1'b0;
            end
         end
         S_RUN: begin
            sig_d = w_next;
            cnt_d = cnt_q + CW'(1);
            if (w_last) begin
               match_d = (w_next == golden);
            end
         end
         default: begin
            sig_d   = '0;
            cnt_d   = '0;
            match_d = 1'b0;
         end
      endcase
   end

   // Datapath and flag registers; reset discards any partial signature.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q   <= '0;
         cnt_q   <= '0;
         match_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sig_out = sig_q;
   assign cnt     = cnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign match   = match_q;

endmodule
`default_nettype wire

// File: tb/tb_y_misr_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_y_misr_compactor                                          |
// | Description : Self-checking bench for y_misr_compactor using small 8-bit   |
// |               configurations and the default 82-bit configuration.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_y_misr_compactor;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // 8-bit, NUM_VEC = 4, SEED = 0
   logic        s4;
   logic [7:0]  y4, g4, sig4;
   logic [15:0] cnt4;
   logic        busy4, done4, match4;
   // 8-bit, NUM_VEC = 2, SEED = 0
   logic        s2;
   logic [7:0]  y2, g2, sig2;
   logic [15:0] cnt2;
   logic        busy2, done2, match2;
   // 8-bit, NUM_VEC = 1, SEED = 1
   logic        s1;
   logic [7:0]  y1, g1, sig1;
   logic [15:0] cnt1;
   logic        busy1, done1, match1;
   // default 82-bit configuration
   logic        s82;
   logic [81:0] y82, g82, sig82;
   logic [15:0] cnt82;
   logic        busy82, done82, match82;

   y_misr_compactor #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .NUM_VEC(4), .CW(16)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(s4), .y_in(y4), .golden(g4),
      .sig_out(sig4), .cnt(cnt4), .busy(busy4), .done(done4), .match(match4));

   y_misr_compactor #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .NUM_VEC(2), .CW(16)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(s2), .y_in(y2), .golden(g2),
      .sig_out(sig2), .cnt(cnt2), .busy(busy2), .done(done2), .match(match2));

   y_misr_compactor #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h01), .NUM_VEC(1), .CW(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .y_in(y1), .golden(g1),
      .sig_out(sig1), .cnt(cnt1), .busy(busy1), .done(done1), .match(match1));

   y_misr_compactor u_dut82 (
      .clk(clk), .rst_n(rst_n), .start(s82), .y_in(y82), .golden(g82),
      .sig_out(sig82), .cnt(cnt82), .busy(busy82), .done(done82), .match(match82));

   // Samples of the run currently being modelled.
   logic [81:0] samples[$];

   // Reference signature: polynomial shift-and-fold of every sample in order,
   // using plain arithmetic on a w-bit value.
   function automatic logic [81:0] sig_model(input int w, input logic [81:0] poly,
                                             input logic [81:0] seed);
      logic [81:0] s;
      logic [81:0] mask;
      logic [81:0] top;
      mask = {82{1'b1}} >> (82 - w);
      s    = seed;
      foreach (samples[i]) begin
         top = (s >> (w - 1)) & 82'd1;
         s   = ((s << 1) & mask) ^ ((top != 0) ? poly : 82'd0) ^ (samples[i] & mask);
      end
      return s;
   endfunction

   function automatic logic [81:0] rand82();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({sig4, cnt4, busy4, done4, match4} !== '0) begin
         n_fail++;
         $display("FAIL reset_dut4: got sig=%h cnt=%0d busy=%b done=%b match=%b, expected all 0",
                  sig4, cnt4, busy4, done4, match4);
      end
      n_tests++;
      if ({sig82, cnt82, busy82, done82, match82} !== '0) begin
         n_fail++;
         $display("FAIL reset_dut82: got sig=%h cnt=%0d busy=%b done=%b match=%b, expected all 0",
                  sig82, cnt82, busy82, done82, match82);
      end
      n_tests++;
      if ({sig2, cnt2, busy2, done2, match2, sig1, cnt1, busy1, done1, match1} !== '0) begin
         n_fail++;
         $display("FAIL reset_dut2_dut1: got sig2=%h sig1=%h busy2=%b busy1=%b, expected all 0",
                  sig2, sig1, busy2, busy1);
      end
      rst_n = 1'b1;
      tick();
   endtask

   // One NUM_VEC = 4 run with random samples; optional stray start in RUN.
   task automatic run4(input bit stray_start, input bit good, input string tag);
      logic [7:0] exp;
      bit         early = 0;
      samples.delete();
      s4 = 1'b1;
      tick();
      s4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         y4 = 8'($urandom);
         samples.push_back({74'd0, y4});
         if (i == 3) begin
            exp = 8'(sig_model(8, 82'h1D, 82'h0));
            g4  = good ? exp : (exp ^ 8'(1 << $urandom_range(7, 0)));
         end
         if (stray_start && i == 1) s4 = 1'b1;
         tick();
         s4 = 1'b0;
         if (i < 3 && (done4 !== 1'b0 || busy4 !== 1'b1)) early = 1;
      end
      n_tests++;
      if (early) begin
         n_fail++;
         $display("FAIL %s_latency: done/busy wrong before 4th absorb, expected busy=1 done=0", tag);
      end
      n_tests++;
      if ({sig4, cnt4, busy4, done4, match4} !== {exp, 16'd4, 1'b0, 1'b1, good}) begin
         n_fail++;
         $display("FAIL %s_result: got sig=%h cnt=%0d busy=%b done=%b match=%b, expected sig=%h cnt=4 busy=0 done=1 match=%b",
                  tag, sig4, cnt4, busy4, done4, match4, exp, good);
      end
      // DONE must hold regardless of y_in
      y4 = 8'($urandom);
      tick();
      n_tests++;
      if ({sig4, cnt4, done4, match4} !== {exp, 16'd4, 1'b1, good}) begin
         n_fail++;
         $display("FAIL %s_hold: got sig=%h cnt=%0d done=%b match=%b, expected sig=%h cnt=4 done=1 match=%b",
                  tag, sig4, cnt4, done4, match4, exp, good);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] exp;
      samples.delete();
      s4 = 1'b1;
      tick();
      s4 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         y4 = 8'($urandom);
         samples.push_back({74'd0, y4});
         tick();
      end
      exp = 8'(sig_model(8, 82'h1D, 82'h0));
      n_tests++;
      if ({sig4, cnt4, busy4} !== {exp, 16'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL midrun_partial: got sig=%h cnt=%0d busy=%b, expected sig=%h cnt=2 busy=1",
                  sig4, cnt4, busy4, exp);
      end
      rst_n = 1'b0;
      s4    = 1'b1;
      tick();
      rst_n = 1'b1;
      s4    = 1'b0;
      n_tests++;
      if ({sig4, cnt4, busy4, done4, match4} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset: got sig=%h cnt=%0d busy=%b done=%b match=%b, expected all 0",
                  sig4, cnt4, busy4, done4, match4);
      end
      tick();
      n_tests++;
      if ({sig4, busy4, done4} !== '0) begin
         n_fail++;
         $display("FAIL midrun_idle_hold: got sig=%h busy=%b done=%b, expected idle zeros",
                  sig4, busy4, done4);
      end
      run4(1'b0, 1'b1, "midrun_restart");
   endtask

   task automatic test_basic(input logic [7:0] gold, input logic exp_match, input string tag);
      s2 = 1'b1;
      tick();
      s2 = 1'b0;
      n_tests++;
      if ({sig2, cnt2, busy2, done2} !== {8'h00, 16'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL %s_seed: got sig=%h cnt=%0d busy=%b done=%b, expected sig=00 cnt=0 busy=1 done=0",
                  tag, sig2, cnt2, busy2, done2);
      end
      y2 = 8'h80;
      tick();
      n_tests++;
      if ({sig2, cnt2, done2} !== {8'h80, 16'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL %s_edge1: got sig=%h cnt=%0d done=%b, expected sig=80 cnt=1 done=0",
                  tag, sig2, cnt2, done2);
      end
      y2 = 8'h00;
      g2 = gold;
      tick();
      n_tests++;
      if ({sig2, cnt2, busy2, done2, match2} !== {8'h1D, 16'd2, 1'b0, 1'b1, exp_match}) begin
         n_fail++;
         $display("FAIL %s_edge2: got sig=%h cnt=%0d busy=%b done=%b match=%b, expected sig=1d cnt=2 busy=0 done=1 match=%b",
                  tag, sig2, cnt2, busy2, done2, match2, exp_match);
      end
   endtask

   task automatic test_num_vec1_restart();
      y1 = 8'h01;
      g1 = 8'h03;
      for (int r = 0; r < 2; r++) begin
         s1 = 1'b1;
         tick();
         s1 = 1'b0;
         n_tests++;
         if ({sig1, cnt1, busy1, done1} !== {8'h01, 16'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL nv1_seed_%0d: got sig=%h cnt=%0d busy=%b done=%b, expected sig=01 cnt=0 busy=1 done=0",
                     r, sig1, cnt1, busy1, done1);
         end
         tick();
         n_tests++;
         if ({sig1, cnt1, busy1, done1, match1} !== {8'h03, 16'd1, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL nv1_done_%0d: got sig=%h cnt=%0d busy=%b done=%b match=%b, expected sig=03 cnt=1 busy=0 done=1 match=1",
                     r, sig1, cnt1, busy1, done1, match1);
         end
      end
   endtask

   task automatic test_default_82(input bit good, input int run);
      logic [81:0] exp;
      bit          early = 0;
      samples.delete();
      s82 = 1'b1;
      tick();
      s82 = 1'b0;
      for (int i = 0; i < 21; i++) begin
         y82 = rand82();
         samples.push_back(y82);
         if (i == 20) begin
            exp = sig_model(82, 82'h61, 82'h1);
            g82 = good ? exp : (exp ^ (82'd1 << $urandom_range(81, 0)));
         end
         tick();
         if (i < 20 && (done82 !== 1'b0 || busy82 !== 1'b1)) early = 1;
      end
      n_tests++;
      if (early) begin
         n_fail++;
         $display("FAIL w82_latency_%0d: done/busy wrong before 21st absorb", run);
      end
      n_tests++;
      if ({sig82, cnt82, busy82, done82, match82} !== {exp, 16'd21, 1'b0, 1'b1, good}) begin
         n_fail++;
         $display("FAIL w82_result_%0d: got sig=%h cnt=%0d done=%b match=%b, expected sig=%h cnt=21 done=1 match=%b",
                  run, sig82, cnt82, done82, match82, exp, good);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      s4 = 0; s2 = 0; s1 = 0; s82 = 0;
      y4 = 0; y2 = 0; y1 = 0; y82 = '0;
      g4 = 0; g2 = 0; g1 = 0; g82 = '0;
      test_reset();
      test_reset_mid_run();
      test_basic(8'h1D, 1'b1, "basic");
      test_basic(8'h1C, 1'b0, "mismatch");
      run4(1'b1, 1'b1, "start_in_run");
      for (int k = 0; k < 4; k++) begin
         run4(1'b0, k[0], "random4");
      end
      test_num_vec1_restart();
      for (int k = 0; k < 3; k++) begin
         test_default_82(k != 1, k);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
